spi_master: RTL and testbench

- SPI mode-0 initiator. Shifts one fixed-width frame out on MOSI and captures the same number of bits from MISO.
- Drives the existing in-fabric SPI slave receiver. Used for loopback self-test of the matrix-data link and for driving external SPI peripherals from the panel controller.
- Frame format matches the slave: MSB first, CS active low, data sampled on SCK rising edge.

---
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_master.sv | 165 ++++++++++++++++
 tb/tb_spi_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Handshake and SPI pin bundle for spi_master.
// The master modport is the initiator side; the slave modport is the user/responder side.
interface spi_master_if #(
    parameter int DATA_BITS = 21
);
    logic                 start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 sck;
    logic                 cs;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sck, cs, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sck, cs, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_BITS frame per start, CS active low, sample on SCK rise.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first (RX fills from the MSB downward).
module spi_master #(
    parameter int DATA_BITS = 21,
    parameter int CLK_DIV   = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q;
    logic [CNT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] tx_sreg, rx_sreg, rx_data_q;
    logic [DATA_BITS-1:0] tx_next, rx_next;
    logic                 sck_q, cs_q, mosi_q, busy_q, done_q;
    logic                 phase_end, accept, do_rise, do_fall, do_hold, do_finish, do_release;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam int TX_BIT = 0;
    assign tx_next = tx_sreg >> 1;
    assign rx_next = {bus.miso, rx_sreg[DATA_BITS-1:1]};
`else
    localparam int TX_BIT = DATA_BITS - 1;
    assign tx_next = tx_sreg << 1;
    assign rx_next = {rx_sreg[DATA_BITS-2:0], bus.miso};
`endif

    assign phase_end = (div_q == DIV_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        do_hold    = 1'b0;
        do_finish  = 1'b0;
        do_release = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                    do_rise = 1'b1;
                end
            end
            SHIFT_HI: begin
                // The final low phase doubles as the CS hold phase.
                if (phase_end) begin
                    if (bit_q == BITS_LAST) begin
                        state_d = HOLD;
                        do_hold = 1'b1;
                    end else begin
                        state_d = SHIFT_LO;
                        do_fall = 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                    do_rise = 1'b1;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d   = GAP;
                    do_finish = 1'b1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d    = IDLE;
                    do_release = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            bit_q     <= '0;
            tx_sreg   <= '0;
            rx_sreg   <= '0;
            rx_data_q <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= do_finish;

            if (state_q == IDLE || phase_end) div_q <= '0;
            else                              div_q <= div_q + 1'b1;

            if (accept) begin
                tx_sreg <= bus.tx_data;
                bit_q   <= '0;
                cs_q    <= 1'b0;
                busy_q  <= 1'b1;
                mosi_q  <= bus.tx_data[TX_BIT];
            end

            if (do_rise) begin
                sck_q   <= 1'b1;
                bit_q   <= bit_q + 1'b1;
                rx_sreg <= rx_next;
            end

            if (do_fall) begin
                sck_q   <= 1'b0;
                tx_sreg <= tx_next;
                mosi_q  <= tx_next[TX_BIT];
            end

            if (do_hold) begin
                sck_q  <= 1'b0;
                mosi_q <= 1'b0;
            end

            if (do_finish) begin
                cs_q      <= 1'b1;
                rx_data_q <= rx_sreg;
            end

            if (do_release) busy_q <= 1'b0;
        end
    end

    assign bus.sck     = sck_q;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frames, a monitor checks them at done.
// Builds with or without SPI_MASTER_LSB_FIRST_EN; expected wire order follows the macro.
module tb_spi_master;
    localparam int N = 21;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_master_if #(.DATA_BITS(N)) bus ();

    spi_master #(.DATA_BITS(N), .CLK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rx;
        logic [N-1:0] wire_tx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Order in which the bits of a word travel on the wire, as an MSB-first word.
    function automatic logic [N-1:0] wire_order(input logic [N-1:0] x);
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < N; i++) wire_order[i] = x[N-1-i];
`else
        wire_order = x;
`endif
    endfunction

    // Responder: loads resp_word at CS fall, MSB first, changes on SCK falls; or loops MOSI back.
    logic [N-1:0] resp_word = '0;
    logic [N-1:0] resp_sh   = '0;
    logic         loopback  = 1'b0;
    logic         miso_r    = 1'b0;

    assign bus.miso = loopback ? bus.mosi : miso_r;

    always @(negedge bus.cs) begin
        resp_sh = resp_word;
        miso_r  = resp_sh[N-1];
    end

    always @(negedge bus.sck) begin
        if (!bus.cs) begin
            resp_sh = resp_sh << 1;
            miso_r  = resp_sh[N-1];
        end
    end

    // Monitor
    logic         sck_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0, wait_busy = 1'b0;
    int           cs_fall_c = 0, first_rise_c = 0, last_rise_c = 0, rises = 0, done_c = 0;
    logic [N-1:0] mosi_cap = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rises     = 0;
            wait_busy = 1'b0;
        end else begin
            if (cs_p && !bus.cs) begin
                cs_fall_c = cyc;
                rises     = 0;
            end
            if (!sck_p && bus.sck) begin
                if (rises == 0) first_rise_c = cyc;
                last_rise_c = cyc;
                rises++;
                mosi_cap = {mosi_cap[N-2:0], bus.mosi};
            end
            if (bus.done) begin
                check("done_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rx_data", 32'(bus.rx_data), 32'(e.rx));
                    check("mosi_bits", 32'(mosi_cap), 32'(e.wire_tx));
                    check("sck_rises", rises, N);
                    check("first_rise_delay", first_rise_c - cs_fall_c, D);
                    check("rise_span", last_rise_c - first_rise_c, 2 * D * (N - 1));
                    check("cs_low_len", cyc - cs_fall_c, D * (2 * N + 1));
                    check("cs_high_at_done", 32'(bus.cs), 32'd1);
                    check("busy_at_done", 32'(bus.busy), 32'd1);
                    done_c    = cyc;
                    wait_busy = 1'b1;
                end
            end
            if (wait_busy && busy_p && !bus.busy) begin
                check("busy_after_done", cyc - done_c, D);
                wait_busy = 1'b0;
            end
        end
        sck_p  = bus.sck;
        cs_p   = bus.cs;
        busy_p = bus.busy;
    end

    // Stimulus helpers
    task automatic issue(input logic [N-1:0] tx, input logic [N-1:0] resp,
                         input logic lb, input logic expect_done);
        @(posedge clk);
        #1;
        resp_word   = resp;
        loopback    = lb;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        if (expect_done)
            sb.push_back('{rx: (lb ? tx : wire_order(resp)), wire_tx: wire_order(tx)});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("cs_after_accept", 32'(bus.cs), 32'd0);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
`ifdef SPI_MASTER_LSB_FIRST_EN
        check("first_mosi", 32'(bus.mosi), 32'(tx[0]));
`else
        check("first_mosi", 32'(bus.mosi), 32'(tx[N-1]));
`endif
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (i == 600) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int n_rise;
        logic sck_prev;

        bus.start   = 1'b0;
        bus.tx_data = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(bus.sck), 32'd0);
        check("rst_cs", 32'(bus.cs), 32'd1);
        check("rst_mosi", 32'(bus.mosi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx", 32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Timing frame with MISO capture, then rx_data held while idle.
        issue(21'h15A5A5, 21'h0F0F0F, 1'b0, 1'b1);
        wait_idle();
        repeat (20) @(negedge clk);
        check("rx_held", 32'(bus.rx_data), 32'(wire_order(21'h0F0F0F)));

        // Start pulsed mid-frame with different data is ignored and not queued.
        issue(21'h1ABCDE, 21'h000000, 1'b0, 1'b1);
        repeat (49) @(posedge clk);
        #1;
        bus.tx_data = 21'h0BADAD;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("no_queued_frame", 32'(bus.busy), 32'd0);

        // Echoing responder: frame 2 returns frame 1's data.
        issue(21'h1ABCDE, 21'h000000, 1'b0, 1'b1);
        wait_idle();
        issue(21'h000001, 21'h1ABCDE, 1'b0, 1'b1);
        wait_idle();

        // Start held high: back-to-back frames, second tx_data taken at the second accept.
        @(posedge clk);
        #1;
        resp_word   = 21'h0AAAAA;
        loopback    = 1'b0;
        bus.tx_data = 21'h055555;
        bus.start   = 1'b1;
        sb.push_back('{rx: wire_order(21'h0AAAAA), wire_tx: wire_order(21'h055555)});
        sb.push_back('{rx: wire_order(21'h133333), wire_tx: wire_order(21'h012345)});
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.cs) break;
        end
        check("held_first_cs", 32'(bus.cs), 32'd0);
        bus.tx_data = 21'h012345;
        resp_word   = 21'h133333;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("held_busy_drop", 32'(bus.busy), 32'd0);
        check("held_cs_idle", 32'(bus.cs), 32'd1);
        @(negedge clk);
        check("held_cs_refall", 32'(bus.cs), 32'd0);
        check("held_busy_rise", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_idle();

        // Loopback of a single set bit.
        issue(21'h000001, 21'h000000, 1'b1, 1'b1);
        wait_idle();
        loopback = 1'b0;

        // Reset at the 10th SCK rise: lines idle immediately, no done, then a clean frame.
        issue(21'h1FFFFF, 21'h1FFFFF, 1'b0, 1'b0);
        n_rise   = 0;
        sck_prev = bus.sck;
        for (i = 0; i < 400 && n_rise < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.sck && !sck_prev) n_rise++;
            sck_prev = bus.sck;
        end
        check("reached_10th_rise", n_rise, 10);
        rst = 1'b1;
        #1;
        check("midrst_sck", 32'(bus.sck), 32'd0);
        check("midrst_cs", 32'(bus.cs), 32'd1);
        check("midrst_mosi", 32'(bus.mosi), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rx", 32'(bus.rx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("no_done_after_rst", 32'(bus.busy), 32'd0);
        issue(21'h0A5A5A, 21'h013579, 1'b0, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
